// File: rtl/phase_slot_arbiter_if.sv
// Bundle between the requesters/phase synchroniser and phase_slot_arbiter.
// Carries the strobe, request, release and grant signals plus the FSM debug view.
interface phase_slot_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int SLOT_W  = 4
);
  // Handshake: a request is a level held in i_req; it is accepted only on a
  // cycle where one i_periodPhased strobe is high and the arbiter is idle.
  // The grant is then held in o_grant until the grantee pulses i_done, drops
  // i_req, or runs out of strobe slots; one dead cycle follows every grant.
  logic [NUM_REQ-1:0] i_periodPhased;
  logic [NUM_REQ-1:0] i_req;
  logic [NUM_REQ-1:0] i_done;
  logic [SLOT_W-1:0]  i_maxSlots;
  logic [NUM_REQ-1:0] o_grant;
  logic [IDX_W-1:0]   o_grantIdx;
  logic               o_busy;
  logic               o_timeout;
  logic [1:0]         state_dbg;

  modport master (
    output i_periodPhased, i_req, i_done, i_maxSlots,
    input  o_grant, o_grantIdx, o_busy, o_timeout, state_dbg
  );

  modport slave (
    input  i_periodPhased, i_req, i_done, i_maxSlots,
    output o_grant, o_grantIdx, o_busy, o_timeout, state_dbg
  );
endinterface

// File: rtl/phase_slot_arbiter.sv
// Round-robin arbiter that starts grants only on phase strobes (IDLE/GRANT/RELEASE).
// Define PHASE_SLOT_ARBITER_TIMEOUT_EN to enable the strobe-slot timeout.
module phase_slot_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int SLOT_W  = 4
) (
  input logic                 i_clock,
  input logic                 i_reset,
  phase_slot_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   winner;
  int                 rr_cand;
  logic               any_strobe;
  logic               start;
  logic               done_hit;
  logic               timeout_hit;
  logic               release_hit;
  logic               timeout_pulse;

  assign any_strobe  = |bus.i_periodPhased;
  assign start       = (state_q == S_IDLE) && any_strobe && (|bus.i_req);
  // A dropped request is treated exactly like a done pulse.
  assign done_hit    = bus.i_done[idx_q] || !bus.i_req[idx_q];
  assign release_hit = done_hit || timeout_hit;

  // Scan from the farthest candidate back to idx_q+1 so the nearest one wins.
  always_comb begin
    winner  = idx_q;
    rr_cand = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_cand = (int'(idx_q) + k) % NUM_REQ;
      if (bus.i_req[IDX_W'(rr_cand)]) winner = IDX_W'(rr_cand);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_GRANT;
      S_GRANT:   if (release_hit) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // idx_q doubles as the round-robin pointer: it already holds the grantee
  // when RELEASE is entered, so the pointer update is implicit.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      grant_q <= '0;
      idx_q   <= IDX_W'(NUM_REQ - 1);
    end else if (start) begin
      grant_q <= NUM_REQ'(1) << winner;
      idx_q   <= winner;
    end else if ((state_q == S_GRANT) && release_hit) begin
      grant_q <= '0;
    end
  end

`ifdef PHASE_SLOT_ARBITER_TIMEOUT_EN
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] max_q;
  logic              timeout_q;

  assign timeout_hit   = (max_q != '0) && (slot_q == max_q);
  assign timeout_pulse = timeout_q;

  // The selecting strobe lands in IDLE, so only strobes seen in GRANT count.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      slot_q    <= '0;
      max_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state_q == S_GRANT) && timeout_hit && !done_hit;
      if (start) begin
        slot_q <= '0;
        max_q  <= bus.i_maxSlots;
      end else if (state_q == S_GRANT) begin
        if (any_strobe && (slot_q != '1)) slot_q <= slot_q + SLOT_W'(1);
      end else begin
        slot_q <= '0;
      end
    end
  end
`else
  logic [SLOT_W-1:0] unused_max_slots;

  assign unused_max_slots = bus.i_maxSlots;
  assign timeout_hit      = 1'b0;
  assign timeout_pulse    = 1'b0;
`endif

  always_comb begin
    bus.o_grant    = grant_q;
    bus.o_grantIdx = idx_q;
    bus.o_busy     = (state_q != S_IDLE);
    bus.o_timeout  = timeout_pulse;
    bus.state_dbg  = state_q;
  end
endmodule

// File: tb/tb_phase_slot_arbiter.sv
// Directed bench for phase_slot_arbiter: vector table plus multi-cycle sequences.
// Timeout checks follow PHASE_SLOT_ARBITER_TIMEOUT_EN; otherwise the no-timeout hold is checked.
module tb_phase_slot_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int SLOT_W  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [IDX_W-1:0] exp_q[$];

  phase_slot_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .SLOT_W(SLOT_W)) bus ();

  phase_slot_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .SLOT_W(SLOT_W)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [NUM_REQ-1:0] strobe;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] exp_grant;
    logic [IDX_W-1:0]   exp_idx;
    logic               exp_busy;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Driver: inputs change 1 time unit after the edge, outputs read 1 unit after the next edge.
  task automatic apply(input logic [NUM_REQ-1:0] strobe, input logic [NUM_REQ-1:0] req,
                       input logic [NUM_REQ-1:0] done, input logic [SLOT_W-1:0] max_slots);
    bus.i_periodPhased = strobe;
    bus.i_req          = req;
    bus.i_done         = done;
    bus.i_maxSlots     = max_slots;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [NUM_REQ-1:0] g,
                               input logic [IDX_W-1:0] idx, input logic busy, input logic to);
    check({tag, " grant"}, 32'(bus.o_grant), 32'(g));
    check({tag, " idx"}, 32'(bus.o_grantIdx), 32'(idx));
    check({tag, " busy"}, 32'(bus.o_busy), 32'(busy));
    check({tag, " timeout"}, 32'(bus.o_timeout), 32'(to));
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.i_periodPhased = '0;
    bus.i_req          = '0;
    bus.i_done         = '0;
    bus.i_maxSlots     = '0;
    #1;
    check_outputs("reset", 4'b0000, 2'd3, 1'b0, 1'b0);
    check("reset state", 32'(bus.state_dbg), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [IDX_W-1:0] e;
    logic [NUM_REQ-1:0] one_hot;

    // strobe, req, done -> grant, idx, busy (state after the edge)
    vecs[0]  = '{4'b0000, 4'b0101, 4'b0000, 4'b0000, 2'd3, 1'b0};
    vecs[1]  = '{4'b0001, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1};
    vecs[2]  = '{4'b0000, 4'b0101, 4'b0001, 4'b0000, 2'd0, 1'b1};
    vecs[3]  = '{4'b0000, 4'b0101, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[4]  = '{4'b0010, 4'b0101, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[5]  = '{4'b0000, 4'b0101, 4'b0001, 4'b0100, 2'd2, 1'b1};
    vecs[6]  = '{4'b0100, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1};
    vecs[7]  = '{4'b0000, 4'b0101, 4'b0100, 4'b0000, 2'd2, 1'b1};
    vecs[8]  = '{4'b1000, 4'b0101, 4'b0000, 4'b0000, 2'd2, 1'b0};
    vecs[9]  = '{4'b0001, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1};
    vecs[10] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b1};
    vecs[11] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[12] = '{4'b0010, 4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b1};
    vecs[13] = '{4'b0000, 4'b1001, 4'b1000, 4'b0000, 2'd3, 1'b1};
    vecs[14] = '{4'b0000, 4'b1001, 4'b0000, 4'b0000, 2'd3, 1'b0};
    vecs[15] = '{4'b0001, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1};
    vecs[16] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1};
    vecs[17] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[18] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[19] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[20] = '{4'b1000, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1};
    vecs[21] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b1};
    vecs[22] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b0};

    #2;
    do_reset();

    for (int i = 0; i < 23; i++) begin
      apply(vecs[i].strobe, vecs[i].req, vecs[i].done, 4'd0);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_idx,
                    vecs[i].exp_busy, 1'b0);
    end

    // Full round robin with every requester active; scoreboard holds the expected order.
    do_reset();
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int g = 0; g < 5; g++) begin
      apply(4'b0001 << (g % 4), 4'b1111, 4'b0000, 4'd0);
      e       = exp_q.pop_front();
      one_hot = 4'b0001 << e;
      check($sformatf("rr%0d idx", g), 32'(bus.o_grantIdx), 32'(e));
      check($sformatf("rr%0d grant", g), 32'(bus.o_grant), 32'(one_hot));
      apply(4'b0000, 4'b1111, 4'b0000, 4'd0);
      apply(4'b0000, 4'b1111, 4'b0000, 4'd0);
      apply(4'b0000, 4'b1111, one_hot, 4'd0);
      check($sformatf("rr%0d release grant", g), 32'(bus.o_grant), 32'd0);
      check($sformatf("rr%0d release busy", g), 32'(bus.o_busy), 32'd1);
      apply(4'b0000, 4'b1111, 4'b0000, 4'd0);
      check($sformatf("rr%0d idle busy", g), 32'(bus.o_busy), 32'd0);
    end
    check("rr queue drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a grant to requester 3.
    apply(4'b0001, 4'b1000, 4'b0000, 4'd0);
    check_outputs("pre-reset", 4'b1000, 2'd3, 1'b1, 1'b0);
    apply(4'b0000, 4'b1000, 4'b0000, 4'd0);
    rst_n = 1'b0;
    #1;
    check_outputs("mid reset", 4'b0000, 2'd3, 1'b0, 1'b0);
    check("mid reset state", 32'(bus.state_dbg), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(4'b0000, 4'b1111, 4'b0000, 4'd0);
    check_outputs("post reset no strobe", 4'b0000, 2'd3, 1'b0, 1'b0);
    apply(4'b0100, 4'b1111, 4'b0000, 4'd0);
    check_outputs("post reset first", 4'b0001, 2'd0, 1'b1, 1'b0);

`ifdef PHASE_SLOT_ARBITER_TIMEOUT_EN
    // Timeout after two post-grant strobes; the later i_maxSlots change must not matter.
    do_reset();
    apply(4'b0001, 4'b0110, 4'b0000, 4'd2);
    check_outputs("to grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    apply(4'b0010, 4'b0110, 4'b0000, 4'd0);
    check_outputs("to slot1", 4'b0010, 2'd1, 1'b1, 1'b0);
    apply(4'b0100, 4'b0110, 4'b0000, 4'd0);
    check_outputs("to slot2", 4'b0010, 2'd1, 1'b1, 1'b0);
    apply(4'b0000, 4'b0110, 4'b0000, 4'd0);
    check_outputs("to release", 4'b0000, 2'd1, 1'b1, 1'b1);
    apply(4'b0000, 4'b0110, 4'b0000, 4'd0);
    check_outputs("to idle", 4'b0000, 2'd1, 1'b0, 1'b0);
    apply(4'b1000, 4'b0110, 4'b0000, 4'd0);
    check_outputs("to next", 4'b0100, 2'd2, 1'b1, 1'b0);
    apply(4'b0000, 4'b0110, 4'b0100, 4'd0);
    apply(4'b0000, 4'b0110, 4'b0000, 4'd0);

    // Done arriving on the timeout cycle wins.
    apply(4'b0001, 4'b0110, 4'b0000, 4'd2);
    check_outputs("dw grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    apply(4'b0010, 4'b0110, 4'b0000, 4'd2);
    apply(4'b0100, 4'b0110, 4'b0000, 4'd2);
    check_outputs("dw slot2", 4'b0010, 2'd1, 1'b1, 1'b0);
    apply(4'b0000, 4'b0110, 4'b0010, 4'd2);
    check_outputs("dw release", 4'b0000, 2'd1, 1'b1, 1'b0);
    apply(4'b0000, 4'b0110, 4'b0000, 4'd2);
    check_outputs("dw idle", 4'b0000, 2'd1, 1'b0, 1'b0);
`else
    // Without the timeout feature a grant outlives any number of strobes.
    do_reset();
    apply(4'b0001, 4'b0010, 4'b0000, 4'd1);
    check_outputs("hold grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 22; i++) begin
      apply(4'b0001 << (i % 4), 4'b0010, 4'b0000, 4'd1);
      check($sformatf("hold%0d grant", i), 32'(bus.o_grant), 32'(4'b0010));
      check($sformatf("hold%0d timeout", i), 32'(bus.o_timeout), 32'd0);
    end
    apply(4'b0000, 4'b0010, 4'b0010, 4'd1);
    check_outputs("hold release", 4'b0000, 2'd1, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/phase_slot_arbiter.md
PHASE_SLOT_ARBITER -- requirements
Module: phase_slot_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters and phase strobes (2..8).
REQ-002 SHALL have parameter IDX_W, default 2, grant index width, equal to clog2(NUM_REQ).
REQ-003 SHALL have parameter SLOT_W, default 4, width of the timeout slot counter.
REQ-004 SHALL have port i_clock  input  1  single clock; every flop is on its rising edge.
REQ-005 SHALL have port i_reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_periodPhased  input  NUM_REQ  one-cycle phase strobes from the clock synchroniser; one or none set per cycle.
REQ-007 SHALL have port i_req  input  NUM_REQ  per-requester level request.
REQ-008 SHALL have port i_done  input  NUM_REQ  per-requester one-cycle release pulse.
REQ-009 SHALL have port i_maxSlots  input  SLOT_W  strobes allowed per grant; 0 means unlimited.
REQ-010 SHALL have port o_grant  output  NUM_REQ  one-hot grant; all zero when idle.
REQ-011 SHALL have port o_grantIdx  output  IDX_W  index of the current or last grantee.
REQ-012 SHALL have port o_busy  output  1  high in GRANT and RELEASE.
REQ-013 SHALL have port o_timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, GRANT, RELEASE.
REQ-015 In IDLE, when any i_periodPhased bit and any i_req bit are high, SHALL pick a winner by round robin and go to GRANT.
- Round robin searches from (last grantee + 1) mod NUM_REQ upward, wrapping.
- Grants begin only on a phase strobe; requests arriving between strobes wait.
REQ-016 o_grant and o_grantIdx SHALL be registered and valid the cycle after the selecting strobe (latency 1).
REQ-017 In GRANT, the slot counter SHALL increment on each i_periodPhased strobe.
- The selecting strobe is not counted.
REQ-018 GRANT SHALL go to RELEASE on any of:
- i_done[grantee];
- i_req[grantee] low, treated as done;
- slot count equal to a nonzero i_maxSlots, which is a timeout.
REQ-019 When done and timeout occur in the same cycle, done SHALL win and o_timeout SHALL stay low.
REQ-020 i_done bits of non-grantees SHALL be ignored.
REQ-021 RELEASE SHALL last exactly one cycle with o_grant zero.
- Round-robin pointer updates to the grantee.
- Slot counter clears.
- Next state is IDLE.
- Guarantees one dead cycle between grants.
REQ-022 o_timeout SHALL pulse for exactly the cycle entering RELEASE on timeout.
REQ-023 i_maxSlots SHALL be sampled at grant start; later changes SHALL take effect only at the next grant.
REQ-024 The slot counter SHALL saturate at all-ones and never wrap.

Reset
REQ-025 While i_reset is low, all outputs SHALL be forced asynchronously:
- o_grant = 0, o_grantIdx = NUM_REQ-1 (so requester 0 wins first), o_busy = 0, o_timeout = 0;
- FSM = IDLE, counter = 0.
REQ-026 Reset asserted mid-grant SHALL drop o_grant immediately, with no RELEASE cycle.
REQ-027 Reset release SHALL be followed by the next strobe before any grant.

Configuration
REQ-028 Macro PHASE_SLOT_ARBITER_TIMEOUT_EN SHALL control the timeout feature.
- Defined: slot counter, i_maxSlots and o_timeout behave per REQ-017/018/022/024.
- Undefined: counter is removed; i_maxSlots is ignored; o_timeout is tied to 0; grants end only on done or dropped request.

Verification
REQ-029 Reset, then i_req=4'b0101 with strobes on phase 0..3 every 10 cycles -> grants alternate 0,2,0,2; each grant starts 1 cycle after a strobe; 1-cycle gap between grants.
REQ-030 i_req=4'b1111, each grantee pulses i_done 3 cycles after grant -> grant order 0,1,2,3,0.
REQ-031 i_maxSlots=2, requester 1 never done -> o_timeout pulses once after 2 post-grant strobes; o_grant clears the same cycle; requester 2 is granted next if requesting.
REQ-032 i_maxSlots=2 with i_done[1] on the timeout cycle -> no o_timeout pulse; normal release.
REQ-033 Reset asserted low during GRANT of requester 3 -> o_grant=0 asynchronously; after release, first grant goes to requester 0.
REQ-034 Build without PHASE_SLOT_ARBITER_TIMEOUT_EN, i_maxSlots=1 -> grant held more than 20 strobes; o_timeout stays 0.
